// File: rtl/pifo_root_pkg.sv
// Shared definitions for the root PIFO calendar.
// Holds the default descriptor layout (field widths and bit positions),
// a packed descriptor struct and small field-extraction helpers.
package pifo_root_pkg;

  localparam int DFLT_BUFFER_ADDR_WIDTH        = 12;
  localparam int DFLT_PIFO_RANK_WIDTH          = 19;
  localparam int DFLT_PIFO_ROOT_WIDTH          = 32;
  localparam int DFLT_ROOT_RANK_START_POS      = 12;
  localparam int DFLT_ROOT_RANK_END_POS        = 30;
  localparam int DFLT_ROOT_PIFO_INFO_VALID_POS = 31;
  localparam int DFLT_CALENDAR_DEPTH           = 16;

  // Descriptor layout, MSB first: valid | rank | buffer address.
  typedef struct packed {
    logic                              valid;
    logic [DFLT_PIFO_RANK_WIDTH-1:0]   rank;
    logic [DFLT_BUFFER_ADDR_WIDTH-1:0] buf_addr;
  } root_desc_t;

  function automatic logic [DFLT_PIFO_RANK_WIDTH-1:0] get_rank(
    input logic [DFLT_PIFO_ROOT_WIDTH-1:0] desc
  );
    return desc[DFLT_ROOT_RANK_END_POS:DFLT_ROOT_RANK_START_POS];
  endfunction

  function automatic logic get_valid(
    input logic [DFLT_PIFO_ROOT_WIDTH-1:0] desc
  );
    return desc[DFLT_ROOT_PIFO_INFO_VALID_POS];
  endfunction

endpackage

// File: rtl/pifo_calendar_slot.sv
// One calendar slot: a descriptor register plus its hold/shift/load mux.
// Ports:
//   clk, rstn        clock, async active-low reset
//   prev_entry       contents of slot i-1 (zero for slot 0)
//   next_entry       contents of slot i+1 (zero for the top slot)
//   new_entry        descriptor being inserted
//   gt_prev, gt_cur  insertion thermometer bits for slots i-1 and i
//   pop, insert      effective (already qualified) pop / insert
//   entry            registered slot contents
module pifo_calendar_slot
  import pifo_root_pkg::*;
#(
  parameter int W = DFLT_PIFO_ROOT_WIDTH
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] prev_entry,
  input  logic [W-1:0] next_entry,
  input  logic [W-1:0] new_entry,
  input  logic         gt_prev,
  input  logic         gt_cur,
  input  logic         pop,
  input  logic         insert,
  output logic [W-1:0] entry
);

  logic [W-1:0] entry_d, entry_q;

  // With a simultaneous pop, gt was computed against the post-pop view
  // (slot i+1). Slots above the insertion point then want view[i-1], which
  // is this slot's own current value, so they simply hold.
  always_comb begin
    entry_d = entry_q;
    case ({insert, pop})
      2'b10: begin
        if (gt_prev)     entry_d = prev_entry;
        else if (gt_cur) entry_d = new_entry;
      end
      2'b01: entry_d = next_entry;
      2'b11: begin
        if (gt_prev)     entry_d = entry_q;
        else if (gt_cur) entry_d = new_entry;
        else             entry_d = next_entry;
      end
      default: entry_d = entry_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/pifo_root_calendar.sv
// Sorted root-level PIFO calendar. Keeps up to CALENDAR_DEPTH descriptors
// in non-decreasing rank order (equal ranks in arrival order) and presents
// the lowest-rank one, registered, as the calendar top.
// Ports:
//   clk, rstn             clock, async active-low reset
//   s_axis_insert_info    descriptor to insert (counts only if its valid bit is set)
//   s_axis_insert_en      insert request
//   s_axis_pop            remove head (ignored when empty)
//   m_axis_calendar_top   slot 0, registered
//   m_axis_count          occupied slots, registered
//   m_axis_full/empty     registered occupancy flags
//   m_axis_drop           one-cycle pulse after an insert rejected on full
module pifo_root_calendar
  import pifo_root_pkg::*;
#(
  parameter int BUFFER_ADDR_WIDTH        = DFLT_BUFFER_ADDR_WIDTH,
  parameter int PIFO_RANK_WIDTH          = DFLT_PIFO_RANK_WIDTH,
  parameter int PIFO_ROOT_WIDTH          = DFLT_PIFO_ROOT_WIDTH,
  parameter int ROOT_RANK_START_POS      = DFLT_ROOT_RANK_START_POS,
  parameter int ROOT_RANK_END_POS        = DFLT_ROOT_RANK_END_POS,
  parameter int ROOT_PIFO_INFO_VALID_POS = DFLT_ROOT_PIFO_INFO_VALID_POS,
  parameter int CALENDAR_DEPTH           = DFLT_CALENDAR_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [PIFO_ROOT_WIDTH-1:0]            s_axis_insert_info,
  input  logic                                  s_axis_insert_en,
  input  logic                                  s_axis_pop,
  output logic [PIFO_ROOT_WIDTH-1:0]            m_axis_calendar_top,
  output logic [$clog2(CALENDAR_DEPTH+1)-1:0]   m_axis_count,
  output logic                                  m_axis_full,
  output logic                                  m_axis_empty,
  output logic                                  m_axis_drop
);

  localparam int CNT_W = $clog2(CALENDAR_DEPTH+1);

  // Layout sanity: rank must fit above the address and below the valid bit.
  if ((ROOT_RANK_END_POS - ROOT_RANK_START_POS + 1) != PIFO_RANK_WIDTH ||
      ROOT_RANK_START_POS < BUFFER_ADDR_WIDTH ||
      ROOT_PIFO_INFO_VALID_POS <= ROOT_RANK_END_POS ||
      ROOT_PIFO_INFO_VALID_POS >= PIFO_ROOT_WIDTH ||
      CALENDAR_DEPTH < 2) begin : g_bad_cfg
    $error("pifo_root_calendar: inconsistent descriptor layout or depth");
  end

  logic [PIFO_ROOT_WIDTH-1:0] slot_entry [CALENDAR_DEPTH];
  logic [CALENDAR_DEPTH-1:0]  gt;
  logic [PIFO_RANK_WIDTH-1:0] new_rank;
  logic                       req_ins, pop_eff, ins_eff;

  logic [CNT_W-1:0] count_d, count_q;
  logic             full_d, full_q, empty_d, empty_q, drop_d, drop_q;

  assign new_rank = s_axis_insert_info[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
  assign req_ins  = s_axis_insert_en & s_axis_insert_info[ROOT_PIFO_INFO_VALID_POS];
  assign pop_eff  = s_axis_pop & ~empty_q;
  assign drop_d   = req_ins & full_q & ~pop_eff;
  assign ins_eff  = req_ins & ~drop_d;

  for (genvar i = 0; i < CALENDAR_DEPTH; i++) begin : g_slot
    logic [PIFO_ROOT_WIDTH-1:0] prev_e, next_e;
    logic [PIFO_RANK_WIDTH-1:0] view_rank;
    logic                       gt_prev, view_valid;

    if (i == CALENDAR_DEPTH-1) begin : g_top
      assign next_e = '0;
    end else begin : g_mid
      assign next_e = slot_entry[i+1];
    end

    if (i == 0) begin : g_bot
      assign prev_e  = '0;
      assign gt_prev = 1'b0;
    end else begin : g_up
      assign prev_e  = slot_entry[i-1];
      assign gt_prev = gt[i-1];
    end

    // Compare against the post-pop view when popping in the same cycle.
    assign view_valid = pop_eff ? next_e[ROOT_PIFO_INFO_VALID_POS]
                                : slot_entry[i][ROOT_PIFO_INFO_VALID_POS];
    assign view_rank  = pop_eff ? next_e[ROOT_RANK_END_POS:ROOT_RANK_START_POS]
                                : slot_entry[i][ROOT_RANK_END_POS:ROOT_RANK_START_POS];
    assign gt[i]      = ~view_valid | (new_rank < view_rank);

    pifo_calendar_slot #(.W(PIFO_ROOT_WIDTH)) u_slot (
      .clk        (clk),
      .rstn       (rstn),
      .prev_entry (prev_e),
      .next_entry (next_e),
      .new_entry  (s_axis_insert_info),
      .gt_prev    (gt_prev),
      .gt_cur     (gt[i]),
      .pop        (pop_eff),
      .insert     (ins_eff),
      .entry      (slot_entry[i])
    );
  end

  always_comb begin
    count_d = count_q;
    if (ins_eff && !pop_eff)      count_d = count_q + CNT_W'(1);
    else if (pop_eff && !ins_eff) count_d = count_q - CNT_W'(1);
    full_d  = (count_d == CNT_W'(CALENDAR_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      drop_q  <= drop_d;
    end
  end

  assign m_axis_calendar_top = slot_entry[0];
  assign m_axis_count        = count_q;
  assign m_axis_full         = full_q;
  assign m_axis_empty        = empty_q;
  assign m_axis_drop         = drop_q;

endmodule

// File: tb/tb_pifo_root_calendar.sv
// Directed self-checking bench for pifo_root_calendar.
module tb_pifo_root_calendar;
  import pifo_root_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s_axis_insert_info;
  logic        s_axis_insert_en;
  logic        s_axis_pop;
  logic [31:0] m_axis_calendar_top;
  logic [4:0]  m_axis_count;
  logic        m_axis_full;
  logic        m_axis_empty;
  logic        m_axis_drop;

  int n_checks = 0;
  int n_errors = 0;

  pifo_root_calendar dut (
    .clk                 (clk),
    .rstn                (rstn),
    .s_axis_insert_info  (s_axis_insert_info),
    .s_axis_insert_en    (s_axis_insert_en),
    .s_axis_pop          (s_axis_pop),
    .m_axis_calendar_top (m_axis_calendar_top),
    .m_axis_count        (m_axis_count),
    .m_axis_full         (m_axis_full),
    .m_axis_empty        (m_axis_empty),
    .m_axis_drop         (m_axis_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic vld, input int rank, input int addr);
    root_desc_t d;
    d.valid    = vld;
    d.rank     = 19'(rank);
    d.buf_addr = 12'(addr);
    return d;
  endfunction

  // Called on a falling edge; applies inputs across one rising edge and
  // returns on the next falling edge with inputs idle.
  task automatic step(input logic ins, input logic [31:0] info, input logic pop);
    s_axis_insert_en   = ins;
    s_axis_insert_info = info;
    s_axis_pop         = pop;
    @(posedge clk);
    @(negedge clk);
    s_axis_insert_en   = 1'b0;
    s_axis_insert_info = '0;
    s_axis_pop         = 1'b0;
  endtask

  function automatic logic [31:0] top_rank();
    return 32'(get_rank(m_axis_calendar_top));
  endfunction

  initial begin
    rstn = 1'b0;
    s_axis_insert_en = 1'b0;
    s_axis_insert_info = '0;
    s_axis_pop = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset state
    chk("rst_top",   m_axis_calendar_top, 32'h0);
    chk("rst_count", 32'(m_axis_count), 32'd0);
    chk("rst_empty", 32'(m_axis_empty), 32'd1);
    chk("rst_full",  32'(m_axis_full), 32'd0);
    chk("rst_drop",  32'(m_axis_drop), 32'd0);

    // Ordered insertion: 50, 10, 30
    step(1'b1, mk(1'b1, 50, 'h0A), 1'b0);
    chk("ins50_top", top_rank(), 32'd50);
    chk("ins50_vld", 32'(get_valid(m_axis_calendar_top)), 32'd1);
    chk("ins50_empty", 32'(m_axis_empty), 32'd0);
    step(1'b1, mk(1'b1, 10, 'h0B), 1'b0);
    chk("ins10_top", top_rank(), 32'd10);
    step(1'b1, mk(1'b1, 30, 'h0C), 1'b0);
    chk("ins30_top", top_rank(), 32'd10);
    chk("ins3_count", 32'(m_axis_count), 32'd3);
    step(1'b0, '0, 1'b1);
    chk("pop1_top", top_rank(), 32'd30);
    chk("pop1_count", 32'(m_axis_count), 32'd2);
    step(1'b0, '0, 1'b1);
    chk("pop2_top", top_rank(), 32'd50);
    chk("pop2_addr", m_axis_calendar_top, mk(1'b1, 50, 'h0A));
    step(1'b0, '0, 1'b1);
    chk("pop3_empty", 32'(m_axis_empty), 32'd1);
    chk("pop3_top", m_axis_calendar_top, 32'h0);
    chk("pop3_count", 32'(m_axis_count), 32'd0);

    // Equal ranks leave in arrival order
    step(1'b1, mk(1'b1, 20, 'h001), 1'b0);
    step(1'b1, mk(1'b1, 20, 'h002), 1'b0);
    chk("tie_first", m_axis_calendar_top, mk(1'b1, 20, 'h001));
    step(1'b0, '0, 1'b1);
    chk("tie_second", m_axis_calendar_top, mk(1'b1, 20, 'h002));
    step(1'b0, '0, 1'b1);
    chk("tie_empty", 32'(m_axis_empty), 32'd1);

    // Fill with ranks 20 down to 5, each landing at slot 0
    for (int k = 0; k < 16; k++) step(1'b1, mk(1'b1, 20 - k, 'h100 + k), 1'b0);
    chk("fill_count", 32'(m_axis_count), 32'd16);
    chk("fill_full",  32'(m_axis_full), 32'd1);
    chk("fill_top",   m_axis_calendar_top, mk(1'b1, 5, 'h10F));

    // Insert while full, no pop: rejected
    step(1'b1, mk(1'b1, 1, 'h0FF), 1'b0);
    chk("drop_pulse", 32'(m_axis_drop), 32'd1);
    chk("drop_count", 32'(m_axis_count), 32'd16);
    chk("drop_top",   m_axis_calendar_top, mk(1'b1, 5, 'h10F));
    step(1'b0, '0, 1'b0);
    chk("drop_clear", 32'(m_axis_drop), 32'd0);

    // Pop + insert while full
    step(1'b1, mk(1'b1, 3, 'h033), 1'b1);
    chk("pi_top",   m_axis_calendar_top, mk(1'b1, 3, 'h033));
    chk("pi_count", 32'(m_axis_count), 32'd16);
    chk("pi_drop",  32'(m_axis_drop), 32'd0);
    chk("pi_full",  32'(m_axis_full), 32'd1);

    // Drain: expect 3, then 6..20 (rank 5 was popped, dropped rank 1 absent)
    for (int k = 0; k < 16; k++) begin
      int exp_rank;
      exp_rank = (k == 0) ? 3 : 5 + k;
      chk($sformatf("drain_%0d", k), top_rank(), 32'(exp_rank));
      step(1'b0, '0, 1'b1);
    end
    chk("drain_empty", 32'(m_axis_empty), 32'd1);
    chk("drain_count", 32'(m_axis_count), 32'd0);

    // Ignored requests: pop on empty, insert with valid bit clear
    step(1'b0, '0, 1'b1);
    chk("pope_count", 32'(m_axis_count), 32'd0);
    chk("pope_drop",  32'(m_axis_drop), 32'd0);
    step(1'b1, mk(1'b0, 7, 'h077), 1'b0);
    chk("inv_count", 32'(m_axis_count), 32'd0);
    chk("inv_empty", 32'(m_axis_empty), 32'd1);
    chk("inv_top",   m_axis_calendar_top, 32'h0);
    chk("inv_drop",  32'(m_axis_drop), 32'd0);

    // Asynchronous reset with 7 entries
    for (int k = 0; k < 7; k++) step(1'b1, mk(1'b1, 40 + k, k), 1'b0);
    chk("pre_rst_count", 32'(m_axis_count), 32'd7);
    #2 rstn = 1'b0;
    #1;
    chk("arst_top",   m_axis_calendar_top, 32'h0);
    chk("arst_count", 32'(m_axis_count), 32'd0);
    chk("arst_empty", 32'(m_axis_empty), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_count", 32'(m_axis_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
